gray_colormap: RTL and testbench
================================

// Module: gray_colormap
// PURPOSE
//  Expands the Q4.4 luma stream from the grayscale stage back into RGB444 pixels
//  for the display/VGA path, converting in the opposite direction.
//  Three per-pixel modes:
//    - gray replicate
//    - 16-entry programmable false-colour palette
//    - binary threshold
//  Two-stage pipeline with valid/ready backpressure. The palette is writable at runtime.
// PARAMETERS
//  DATA_W     12   pixel bus width (upstream gray bus and RGB444 output)
//  LUT_DEPTH  16   palette entries; index = rounded luma integer part (4 bits)
// PORTS
//  i_clk          in   1   single clock, all logic rising-edge
//  i_rstn         in   1   synchronous, active-low reset
//  i_gray_data    in   12  [7:0] = Q4.4 luma (max 0xE1), [11:8] ignored
//  i_gray_valid   in   1   input pixel valid
//  o_gray_ready   out  1   input accepted when i_gray_valid & o_gray_ready
//  i_mode         in   2   0 = GRAY, 1 = LUT, 2 = THRESH, 3 = reserved (treated as GRAY); sampled with the pixel
//  i_thresh       in   4   THRESH mode: index >= i_thresh -> white, else black
//  i_lut_we       in   1   palette write strobe
//  i_lut_addr     in   4   palette write address
//  i_lut_data     in   12  palette entry {R,G,B}
//  o_rgb_data     out  12  {R[3:0],G[3:0],B[3:0]}
//  o_rgb_valid    out  1   output pixel valid
//  i_rgb_ready    in   1   downstream ready
// BEHAVIOUR
//  - Reset (i_rstn = 0 at clock edge):
//      o_rgb_data = 0, o_rgb_valid = 0, both stage valids = 0.
//      Palette[k] = {k,k,k} (gray ramp).
//      o_gray_ready = 1 the cycle after reset releases.
//      Reset mid-stream discards all in-flight pixels; no partial output.
//  - Advance: en = !o_rgb_valid | i_rgb_ready; o_gray_ready = en (combinational).
//      Both stages shift only when en = 1.
//      While stalled: o_rgb_data / o_rgb_valid stay constant, and nothing is dropped
//      or duplicated.
//  - Stage 1, on accept:
//      idx = luma[7:4] + luma[3], round half up, saturate at 15 (0xF8..0xFF -> 15).
//      Register idx and mode.
//      s1_valid <= i_gray_valid.
//  - Stage 2 map:
//      GRAY   -> {idx,idx,idx}
//      LUT    -> palette[idx]
//      THRESH -> (idx >= i_thresh) ? 12'hFFF : 12'h000
//      i_thresh is sampled at stage 2.
//      o_rgb_valid <= s1_valid.
//  - Latency: exactly 2 cycles accept-to-o_rgb_valid with no stall.
//      Throughput: 1 pixel/clk.
//  - Palette writes:
//      Take effect the cycle after i_lut_we; independent of en and of stall state.
//      A write in the same cycle stage 2 reads the same address yields the OLD entry
//      (read-before-write).
//  - Bubbles: i_gray_valid = 0 while en = 1 propagates a bubble.
//      o_rgb_data holds its last value when o_rgb_valid = 0.
//  - Mode changes are per-pixel. No flush is required; pixels already in flight keep
//      the mode they captured.
// STRUCTURE
//  - Shared package gray_pkg:
//      MODE_GRAY / MODE_LUT / MODE_THRESH localparams
//      RGB444 field offsets
//      luma Q4.4 width constant
//  - One sub-module, gray_palette_ram:
//      16x12 register file, synchronous write, combinational read,
//      reset-to-ramp initialisation.
//  - Top: stage 1 rounder, stage 2 mapper, handshake logic.
// TESTING
//  - Rounding: in 0x00, 0x07, 0x08, 0x7F, 0xE1, 0xFF in GRAY mode, ready = 1
//      -> out 0x000, 0x000, 0x111, 0x888, 0xEEE, 0xFFF;
//      each exactly 2 cycles after accept.
//  - Palette: write addr 5 = 0xF00, then pixel 0x50 in LUT mode -> 0xF00.
//      Write addr 5 = 0x0F0 in the same cycle the pixel sits in stage 2 -> 0xF00;
//      the next pixel -> 0x0F0.
//  - Threshold: i_thresh = 8, pixels 0x77 and 0x78 (idx 7, 8) -> 0x000 then 0xFFF.
//  - Backpressure: stream 8 pixels while i_rgb_ready toggles 1,0,0,1...
//      -> all 8 outputs in order, no loss or duplication.
//      Data stable while stalled; o_gray_ready low only when o_rgb_valid & !i_rgb_ready.
//  - Reset mid-stream: assert i_rstn = 0 with 2 pixels in flight
//      -> o_rgb_valid = 0 next cycle, palette back to ramp (LUT idx 3 -> 0x333),
//         and none of the old pixels appear afterwards.
//  - Mixed modes back-to-back: GRAY, LUT, THRESH on consecutive cycles
//      -> each output uses its own captured mode.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared constants for the grayscale-to-RGB444 colour mapping path.
// Holds mode codes, RGB444 field layout and the luma rounding helpers.
package gray_pkg;

  localparam int PIX_W     = 12;
  localparam int PAL_DEPTH = 16;
  localparam int LUMA_W    = 8;
  localparam int IDX_W     = 4;
  localparam int CH_W      = 4;

  localparam int R_LSB = 8;
  localparam int G_LSB = 4;
  localparam int B_LSB = 0;

  localparam logic [1:0] MODE_GRAY   = 2'd0;
  localparam logic [1:0] MODE_LUT    = 2'd1;
  localparam logic [1:0] MODE_THRESH = 2'd2;

  // Q4.4 luma -> 4-bit index: round half up on bit 3, saturate at 15.
  function automatic logic [IDX_W-1:0] round_luma(input logic [LUMA_W-1:0] luma);
    logic [IDX_W:0] sum;
    sum = {1'b0, luma[LUMA_W-1:LUMA_W-IDX_W]} + {{IDX_W{1'b0}}, luma[LUMA_W-IDX_W-1]};
    return sum[IDX_W] ? {IDX_W{1'b1}} : sum[IDX_W-1:0];
  endfunction

  function automatic logic [PIX_W-1:0] gray_rgb(input logic [CH_W-1:0] lvl);
    logic [PIX_W-1:0] rgb;
    rgb = '0;
    rgb[R_LSB +: CH_W] = lvl;
    rgb[G_LSB +: CH_W] = lvl;
    rgb[B_LSB +: CH_W] = lvl;
    return rgb;
  endfunction

endpackage

// File: rtl/gray_palette_ram.sv
// False-colour palette: 16x12 register file, synchronous write, combinational read.
// Reset reloads the gray ramp so LUT mode starts as an identity mapping.
module gray_palette_ram
  import gray_pkg::*;
#(
  parameter int DEPTH = PAL_DEPTH
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  // NOTE: state is written with <= so every reader in the same edge sees the old value.
  // NOTE: this memory is reset on purpose -- the ramp contents are architecturally visible,
  // which forces flops rather than a RAM macro.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= gray_rgb(CH_W'(k));
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read of the pre-edge contents gives read-before-write ordering.
  assign rdata = mem[raddr];

endmodule

// File: rtl/gray_colormap.sv
// Q4.4 luma -> RGB444 expander: stage 1 rounds luma to a palette index, stage 2
// maps it by the captured mode (gray / palette / threshold). Valid/ready pipeline.
module gray_colormap
  import gray_pkg::*;
#(
  parameter int DATA_W    = PIX_W,
  parameter int LUT_DEPTH = PAL_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [DATA_W-1:0] i_gray_data,
  input  logic              i_gray_valid,
  output logic              o_gray_ready,
  input  logic [1:0]        i_mode,
  input  logic [IDX_W-1:0]  i_thresh,
  input  logic              i_lut_we,
  input  logic [IDX_W-1:0]  i_lut_addr,
  input  logic [DATA_W-1:0] i_lut_data,
  output logic [DATA_W-1:0] o_rgb_data,
  output logic              o_rgb_valid,
  input  logic              i_rgb_ready
);

  logic              en;
  logic              s1_valid;
  logic [IDX_W-1:0]  s1_idx;
  logic [1:0]        s1_mode;
  logic [DATA_W-1:0] pal_rdata;
  logic [DATA_W-1:0] map_rgb;
  logic              unused_gray_hi;

  assign unused_gray_hi = ^i_gray_data[DATA_W-1:LUMA_W];

  // Whole pipeline moves together; it stalls only when the output is held unconsumed.
  assign en           = !o_rgb_valid || i_rgb_ready;
  assign o_gray_ready = en;

  gray_palette_ram #(
    .DEPTH (LUT_DEPTH)
  ) u_palette (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .we     (i_lut_we),
    .waddr  (i_lut_addr),
    .wdata  (i_lut_data),
    .raddr  (s1_idx),
    .rdata  (pal_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_mode  <= MODE_GRAY;
    end else if (en) begin
      s1_valid <= i_gray_valid;
      if (i_gray_valid) begin
        s1_idx  <= round_luma(i_gray_data[LUMA_W-1:0]);
        s1_mode <= i_mode;
      end
    end
  end

  // NOTE: map_rgb gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    map_rgb = gray_rgb(s1_idx);
    case (s1_mode)
      MODE_LUT:    map_rgb = pal_rdata;
      MODE_THRESH: map_rgb = (s1_idx >= i_thresh) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
      default:     map_rgb = gray_rgb(s1_idx);
    endcase
  end

  // Output data only loads on a real pixel, so it holds through bubbles.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_rgb_valid <= 1'b0;
      o_rgb_data  <= '0;
    end else if (en) begin
      o_rgb_valid <= s1_valid;
      if (s1_valid) begin
        o_rgb_data <= map_rgb;
      end
    end
  end

endmodule

// File: tb/tb_gray_colormap.sv
// Self-checking bench for gray_colormap: transaction-level reference model compared
// every cycle, plus directed vectors with hand-computed expected pixels.
module tb_gray_colormap;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic [11:0] i_gray_data;
  logic        i_gray_valid;
  logic        o_gray_ready;
  logic [1:0]  i_mode;
  logic [3:0]  i_thresh;
  logic        i_lut_we;
  logic [3:0]  i_lut_addr;
  logic [11:0] i_lut_data;
  logic [11:0] o_rgb_data;
  logic        o_rgb_valid;
  logic        i_rgb_ready;

  always #5 i_clk = ~i_clk;

  gray_colormap dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_gray_data  (i_gray_data),
    .i_gray_valid (i_gray_valid),
    .o_gray_ready (o_gray_ready),
    .i_mode       (i_mode),
    .i_thresh     (i_thresh),
    .i_lut_we     (i_lut_we),
    .i_lut_addr   (i_lut_addr),
    .i_lut_data   (i_lut_data),
    .o_rgb_data   (o_rgb_data),
    .o_rgb_valid  (o_rgb_valid),
    .i_rgb_ready  (i_rgb_ready)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          chk_en  = 1'b0;
  logic [11:0] cap[$];
  logic [11:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pixel = round(luma/16) clamped, mapped by its own mode when it
  // reaches the output; palette writes land after that edge's lookup.
  logic [11:0] m_pal [16];
  bit          m_s1_v;
  bit          m_out_v;
  int          m_s1_idx;
  logic [1:0]  m_s1_mode;
  logic [11:0] m_out_d;

  function automatic int model_idx(input int luma);
    int r;
    r = (luma + 8) / 16;
    return (r > 15) ? 15 : r;
  endfunction

  function automatic logic [11:0] model_map(input int idx, input logic [1:0] mode,
                                            input logic [3:0] thr);
    case (mode)
      2'd1:    return m_pal[idx];
      2'd2:    return (idx >= int'(thr)) ? 12'hFFF : 12'h000;
      default: return 12'(idx * 12'h111);
    endcase
  endfunction

  always @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int k = 0; k < 16; k++) m_pal[k] <= 12'(k * 12'h111);
      m_s1_v  <= 1'b0;
      m_out_v <= 1'b0;
      m_out_d <= 12'h000;
    end else begin
      if (!m_out_v || i_rgb_ready) begin
        if (m_s1_v) m_out_d <= model_map(m_s1_idx, m_s1_mode, i_thresh);
        m_out_v <= m_s1_v;
        m_s1_v  <= i_gray_valid;
        if (i_gray_valid) begin
          m_s1_idx  <= model_idx(int'(i_gray_data[7:0]));
          m_s1_mode <= i_mode;
        end
      end
      if (i_lut_we) m_pal[i_lut_addr] <= i_lut_data;
    end
  end

  always @(negedge i_clk) begin
    #2;
    if (chk_en) begin
      check("cyc_ready", 32'(o_gray_ready), 32'(!m_out_v || i_rgb_ready));
      check("cyc_valid", 32'(o_rgb_valid), 32'(m_out_v));
      check("cyc_data", 32'(o_rgb_data), 32'(m_out_d));
      if (i_rstn && o_rgb_valid && i_rgb_ready) cap.push_back(o_rgb_data);
    end
  end

  task automatic check_cap(input string name);
    check({name, "_count"}, 32'(cap.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < cap.size()) check(name, 32'(cap[i]), 32'(exp_q[i]));
    end
    cap.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge i_clk);
      i_gray_valid = 1'b0;
      i_lut_we     = 1'b0;
    end
  endtask

  task automatic wr_lut(input logic [3:0] addr, input logic [11:0] data);
    @(negedge i_clk);
    i_gray_valid = 1'b0;
    i_lut_we     = 1'b1;
    i_lut_addr   = addr;
    i_lut_data   = data;
  endtask

  // Presents one pixel and returns once it is sure to be accepted on the next edge.
  task automatic send(input logic [7:0] luma, input logic [1:0] mode);
    int t;
    @(negedge i_clk);
    i_lut_we     = 1'b0;
    i_gray_valid = 1'b1;
    i_gray_data  = {4'h0, luma};
    i_mode       = mode;
    #1;
    t = 0;
    while (!o_gray_ready && t < 50) begin
      @(negedge i_clk);
      #1;
      t++;
    end
    if (!o_gray_ready) check("send_accept", 32'(o_gray_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] rnd_in [6];
    logic [3:0] pat [4];
    int k;
    int cyc;

    rnd_in = '{8'h00, 8'h07, 8'h08, 8'h7F, 8'hE1, 8'hFF};
    pat    = '{4'd1, 4'd0, 4'd0, 4'd1};
    i_gray_valid = 1'b0;
    i_gray_data  = '0;
    i_mode       = 2'd0;
    i_thresh     = 4'd8;
    i_lut_we     = 1'b0;
    i_lut_addr   = '0;
    i_lut_data   = '0;
    i_rgb_ready  = 1'b1;

    // Reset state
    repeat (3) @(negedge i_clk);
    chk_en = 1'b1;
    #3;
    check("rst_valid", 32'(o_rgb_valid), 32'd0);
    check("rst_data", 32'(o_rgb_data), 32'h000);
    i_rstn = 1'b1;
    @(negedge i_clk);
    #3;
    check("post_rst_ready", 32'(o_gray_ready), 32'd1);

    // Rounding and 2-cycle latency, back to back in GRAY mode
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      i_gray_valid = 1'b1;
      i_gray_data  = {4'h0, rnd_in[i]};
      i_mode       = 2'd0;
      #3;
      if (i == 1) check("lat_cyc1_valid", 32'(o_rgb_valid), 32'd0);
      if (i == 2) check("lat_cyc2_valid", 32'(o_rgb_valid), 32'd1);
      if (i == 4) check("lat_px2_data", 32'(o_rgb_data), 32'h111);
      if (i == 5) check("lat_px3_data", 32'(o_rgb_data), 32'h888);
    end
    idle(4);
    exp_q = '{12'h000, 12'h000, 12'h111, 12'h888, 12'hEEE, 12'hFFF};
    check_cap("round");

    // Palette write, then read-before-write collision in stage 2
    wr_lut(4'd5, 12'hF00);
    send(8'h50, 2'd1);
    @(negedge i_clk);
    i_gray_valid = 1'b1;
    i_gray_data  = 12'h050;
    i_mode       = 2'd1;
    i_lut_we     = 1'b0;
    @(negedge i_clk);
    i_gray_valid = 1'b0;
    i_lut_we     = 1'b1;
    i_lut_addr   = 4'd5;
    i_lut_data   = 12'h0F0;
    send(8'h50, 2'd1);
    idle(4);
    exp_q = '{12'hF00, 12'hF00, 12'h0F0};
    check_cap("palette");

    // Threshold boundary at idx 7 / 8
    send(8'h77, 2'd2);
    send(8'h78, 2'd2);
    idle(4);
    exp_q = '{12'h000, 12'hFFF};
    check_cap("thresh");

    // Backpressure: ready pattern 1,0,0,1 while streaming 8 pixels
    k   = 0;
    cyc = 0;
    while (k < 8 && cyc < 100) begin
      @(negedge i_clk);
      i_rgb_ready  = pat[cyc % 4][0];
      i_gray_valid = 1'b1;
      i_gray_data  = 12'((k + 1) * 16);
      i_mode       = 2'd0;
      #1;
      if (o_gray_ready) k++;
      cyc++;
    end
    if (k != 8) check("bp_sent", 32'(k), 32'd8);
    k = 0;
    while (k < 100) begin
      @(negedge i_clk);
      i_gray_valid = 1'b0;
      i_rgb_ready  = pat[cyc % 4][0];
      cyc++;
      k++;
      #3;
      if (cap.size() >= 8) k = 100;
    end
    @(negedge i_clk);
    i_rgb_ready = 1'b1;
    idle(3);
    exp_q = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555, 12'h666, 12'h777, 12'h888};
    check_cap("backpressure");

    // Reset mid-stream with two pixels in flight
    wr_lut(4'd3, 12'hABC);
    i_rgb_ready = 1'b0;
    send(8'h30, 2'd0);
    send(8'h40, 2'd0);
    @(negedge i_clk);
    i_gray_valid = 1'b0;
    i_rstn       = 1'b0;
    @(negedge i_clk);
    #3;
    check("midrst_valid", 32'(o_rgb_valid), 32'd0);
    check("midrst_data", 32'(o_rgb_data), 32'h000);
    check("midrst_nocap", 32'(cap.size()), 32'd0);
    i_rstn      = 1'b1;
    i_rgb_ready = 1'b1;
    cap.delete();
    send(8'h30, 2'd1);
    idle(6);
    exp_q = '{12'h333};
    check_cap("midrst_ramp");

    // Mixed modes back to back, including the reserved code
    wr_lut(4'hA, 12'h5A3);
    send(8'h20, 2'd0);
    send(8'hA0, 2'd1);
    send(8'h90, 2'd2);
    send(8'h60, 2'd3);
    idle(4);
    exp_q = '{12'h222, 12'h5A3, 12'hFFF, 12'h666};
    check_cap("mixed");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
